// File: rtl/neopixel_pkg.sv
// Shared types and helpers for the multi-strand WS2812 driver: ns->cycle conversion,
// FSM state encoding and the ctrl address layout.
package neopixel_pkg;

   localparam int unsigned ADDR_FIELD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_HIGH,
      ST_LOW,
      ST_LATCH
   } state_t;

   // ctrl_address layout: channel in the upper half, pixel index in the lower half
   typedef struct packed {
      logic [ADDR_FIELD_W-1:0] channel;
      logic [ADDR_FIELD_W-1:0] pixel;
   } ctrl_addr_t;

   function automatic int unsigned ns_to_cycles(input longint unsigned freq_hz,
                                                input longint unsigned ns);
      longint unsigned cycles;
      cycles = (freq_hz * ns) / 64'd1_000_000_000;
      return 32'(cycles);
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/neopixel_lane.sv
// One strand: pixel RAM (one write port, one synchronous read port), shift register
// and the registered drive bit.
module neopixel_lane
   import neopixel_pkg::*;
#(
   parameter int unsigned C_PIXELS         = 12,
   parameter int unsigned C_BITS_PER_PIXEL = 24,
   parameter int unsigned PX_W             = 4
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        wr_en,
   input  logic [PX_W-1:0]             wr_addr,
   input  logic [C_BITS_PER_PIXEL-1:0] wr_data,
   input  logic [PX_W-1:0]             rd_addr,
   output logic [C_BITS_PER_PIXEL-1:0] rd_data,
   input  logic                        load,
   input  logic                        shift,
   input  logic                        hi_zero,
   input  logic                        hi_one,
   output logic                        drive
);

   logic [C_BITS_PER_PIXEL-1:0] mem [C_PIXELS];
   logic [C_BITS_PER_PIXEL-1:0] shreg;
   logic [C_BITS_PER_PIXEL-1:0] shreg_nxt;

   // Pixel storage is intentionally not reset
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

   always_comb begin
      shreg_nxt = shreg;
      if (load) begin
         shreg_nxt = rd_data;
      end else if (shift) begin
         shreg_nxt = {shreg[C_BITS_PER_PIXEL-2:0], 1'b0};
      end
   end

   // Drive is decided from next-cycle state so the output stays a plain flop
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shreg <= '0;
         drive <= 1'b0;
      end else begin
         shreg <= shreg_nxt;
         drive <= shreg_nxt[C_BITS_PER_PIXEL-1] ? hi_one : hi_zero;
      end
   end

endmodule

// File: rtl/neopixel_multi.sv
// Multi-strand WS2812 driver: C_CHANNELS lanes sent in lock-step from one bit timer.
// Optional NEOPIXEL_AUTO_REFRESH_EN adds a free-running periodic refresh.
module neopixel_multi
   import neopixel_pkg::*;
#(
   parameter int unsigned C_CHANNELS       = 4,
   parameter int unsigned C_PIXELS         = 12,
   parameter int unsigned C_BITS_PER_PIXEL = 24,
   parameter int unsigned C_FREQ_HZ        = 125000000,
   parameter int unsigned C_T0H_NS         = 400,
   parameter int unsigned C_T1H_NS         = 800,
   parameter int unsigned C_BIT_NS         = 1250,
   parameter int unsigned C_RES_NS         = 80000,
   parameter int unsigned C_REFRESH_HZ     = 60
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  ctrl_write,
   input  logic [31:0]           ctrl_address,
   input  logic [31:0]           ctrl_write_data,
   output logic [31:0]           ctrl_read_data,
   output logic                  ctrl_ready,
   input  logic                  ctrl_refresh,
   output logic                  busy,
   output logic [C_CHANNELS-1:0] neopixel_drive
);

   localparam int unsigned T0H   = ns_to_cycles(64'(C_FREQ_HZ), 64'(C_T0H_NS));
   localparam int unsigned T1H   = ns_to_cycles(64'(C_FREQ_HZ), 64'(C_T1H_NS));
   localparam int unsigned TBIT  = ns_to_cycles(64'(C_FREQ_HZ), 64'(C_BIT_NS));
   localparam int unsigned TRES  = ns_to_cycles(64'(C_FREQ_HZ), 64'(C_RES_NS));
   localparam int unsigned CNT_W = $clog2(max2(TBIT, TRES) + 1);
   localparam int unsigned BIT_W = $clog2(C_BITS_PER_PIXEL);
   localparam int unsigned PX_W  = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1;
   localparam int unsigned CH_W  = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;

   if (!(C_BITS_PER_PIXEL == 24 || C_BITS_PER_PIXEL == 32)) begin : g_bad_bpp
      $error("neopixel_multi: C_BITS_PER_PIXEL must be 24 or 32");
   end
   if (C_REFRESH_HZ == 0) begin : g_bad_refresh
      $error("neopixel_multi: C_REFRESH_HZ must be non-zero");
   end

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [BIT_W-1:0]     bit_idx, bit_idx_n;
   logic [PX_W-1:0]      px, px_n;
   logic                 pend, pend_n;
   logic                 refresh_req;
   logic                 auto_refresh;
   logic                 lane_load;
   logic                 lane_shift;
   logic                 hi_zero;
   logic                 hi_one;

   ctrl_addr_t           addr;
   logic                 addr_ok;
   logic [PX_W-1:0]      px_addr;
   logic [CH_W-1:0]      ch_addr;
   logic                 wr_accept;
   logic [PX_W-1:0]      lane_rd_addr;
   logic [C_BITS_PER_PIXEL-1:0] lane_rdata [C_CHANNELS];

   logic [CH_W-1:0]      rd_ch_q;
   logic                 rd_ok_q;
   logic                 rd_live_q;
   logic [31:0]          rd_hold_q;
   logic                 unused_wdata;

   assign unused_wdata = ^ctrl_write_data;

   // Address decode shared by the write and read paths
   assign addr      = ctrl_address;
   assign addr_ok   = (32'(addr.channel) < C_CHANNELS) && (32'(addr.pixel) < C_PIXELS);
   assign px_addr   = addr_ok ? PX_W'(addr.pixel) : '0;
   assign ch_addr   = CH_W'(addr.channel);
   assign wr_accept = ctrl_write && ctrl_ready && addr_ok;
   // The frame engine owns the lane read port only during LOAD_A
   assign lane_rd_addr = (state == ST_LOAD_A) ? px : px_addr;

`ifdef NEOPIXEL_AUTO_REFRESH_EN
   localparam int unsigned AR_PERIOD = C_FREQ_HZ / C_REFRESH_HZ;
   localparam int unsigned AR_W      = (AR_PERIOD > 1) ? $clog2(AR_PERIOD) : 1;

   logic [AR_W-1:0] ar_cnt;

   assign auto_refresh = (ar_cnt == AR_W'(AR_PERIOD - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ar_cnt <= '0;
      end else if (auto_refresh) begin
         ar_cnt <= '0;
      end else begin
         ar_cnt <= ar_cnt + AR_W'(1);
      end
   end
`else
   assign auto_refresh = 1'b0;
`endif

   assign refresh_req = ctrl_refresh || auto_refresh;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         px         <= '0;
         pend       <= 1'b0;
         busy       <= 1'b0;
         ctrl_ready <= 1'b1;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         px         <= px_n;
         pend       <= pend_n;
         busy       <= (state_n != ST_IDLE);
         ctrl_ready <= (state_n != ST_LOAD_A);
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_idx_n  = bit_idx;
      px_n       = px;
      pend_n     = pend;
      lane_load  = 1'b0;
      lane_shift = 1'b0;

      // Refresh during a frame is remembered once; LATCH consumes it
      if (state != ST_IDLE && refresh_req) begin
         pend_n = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            if (refresh_req) begin
               state_n = ST_LOAD_A;
               px_n    = '0;
            end
         end
         ST_LOAD_A: begin
            state_n   = ST_LOAD_B;
            bit_idx_n = BIT_W'(C_BITS_PER_PIXEL - 1);
         end
         ST_LOAD_B: begin
            lane_load = 1'b1;
            state_n   = ST_HIGH;
            cnt_n     = '0;
         end
         ST_HIGH: begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(T1H - 1)) begin
               state_n = ST_LOW;
            end
         end
         ST_LOW: begin
            if (cnt == CNT_W'(TBIT - 1)) begin
               lane_shift = 1'b1;
               cnt_n      = '0;
               if (bit_idx != '0) begin
                  bit_idx_n = bit_idx - BIT_W'(1);
                  state_n   = ST_HIGH;
               end else if (px != PX_W'(C_PIXELS - 1)) begin
                  px_n    = px + PX_W'(1);
                  state_n = ST_LOAD_A;
               end else begin
                  state_n = ST_LATCH;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_LATCH: begin
            if (cnt == CNT_W'(TRES - 1)) begin
               cnt_n = '0;
               if (pend || refresh_req) begin
                  pend_n  = 1'b0;
                  px_n    = '0;
                  state_n = ST_LOAD_A;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign hi_zero = (state_n == ST_HIGH) && (cnt_n < CNT_W'(T0H));
   assign hi_one  = (state_n == ST_HIGH) && (cnt_n < CNT_W'(T1H));

   for (genvar i = 0; i < int'(C_CHANNELS); i++) begin : g_lane
      neopixel_lane #(
         .C_PIXELS         (C_PIXELS),
         .C_BITS_PER_PIXEL (C_BITS_PER_PIXEL),
         .PX_W             (PX_W)
      ) u_lane (
         .clock   (clock),
         .reset_n (reset_n),
         .wr_en   (wr_accept && (ch_addr == CH_W'(i))),
         .wr_addr (px_addr),
         .wr_data (C_BITS_PER_PIXEL'(ctrl_write_data)),
         .rd_addr (lane_rd_addr),
         .rd_data (lane_rdata[i]),
         .load    (lane_load),
         .shift   (lane_shift),
         .hi_zero (hi_zero),
         .hi_one  (hi_one),
         .drive   (neopixel_drive[i])
      );
   end

   // A read issued in LOAD_A repeats the previous result since the RAM port is busy
   assign ctrl_read_data = !rd_live_q ? rd_hold_q
                         : (rd_ok_q ? 32'(lane_rdata[rd_ch_q]) : 32'd0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ch_q   <= '0;
         rd_ok_q   <= 1'b0;
         rd_live_q <= 1'b1;
         rd_hold_q <= '0;
      end else begin
         rd_ch_q   <= ch_addr;
         rd_ok_q   <= addr_ok;
         rd_live_q <= (state != ST_LOAD_A);
         rd_hold_q <= ctrl_read_data;
      end
   end

endmodule

// File: tb/tb_neopixel_multi.sv
// Self-checking bench for neopixel_multi: randomized pixel data checked cycle-by-cycle
// against a waveform model derived from the WS2812 bit timing rules.
module tb_neopixel_multi;

   localparam int CH    = 4;
   localparam int PX    = 2;
   localparam int BPP   = 24;
   localparam int T0H   = 50;
   localparam int T1H   = 100;
   localparam int TBIT  = 156;
   localparam int TRES  = 1000;
   localparam int PXLEN = 2 + BPP * TBIT;
   localparam int FRAME = PX * PXLEN + TRES;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          ctrl_write;
   logic [31:0]   ctrl_address;
   logic [31:0]   ctrl_write_data;
   logic [31:0]   ctrl_read_data;
   logic          ctrl_ready;
   logic          ctrl_refresh;
   logic          busy;
   logic [CH-1:0] neopixel_drive;

   always #5 clock = ~clock;

   neopixel_multi #(
      .C_CHANNELS       (CH),
      .C_PIXELS         (PX),
      .C_BITS_PER_PIXEL (BPP),
      .C_RES_NS         (8000)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .ctrl_write      (ctrl_write),
      .ctrl_address    (ctrl_address),
      .ctrl_write_data (ctrl_write_data),
      .ctrl_read_data  (ctrl_read_data),
      .ctrl_ready      (ctrl_ready),
      .ctrl_refresh    (ctrl_refresh),
      .busy            (busy),
      .neopixel_drive  (neopixel_drive)
   );

   logic [23:0] model [CH][PX];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Mid-frame stimulus events consumed by check_frame (-1 = unused)
   int          pl_t  [3];
   int          wr_t  [2];
   int          wr_ch [2];
   int          wr_px [2];
   logic [31:0] wr_d  [2];

   task automatic clear_events();
      for (int i = 0; i < 3; i++) pl_t[i] = -1;
      for (int i = 0; i < 2; i++) wr_t[i] = -1;
   endtask

   task automatic model_write(input int ch, input int px, input logic [31:0] d);
      if (ch < CH && px < PX) model[ch][px] = d[23:0];
   endtask

   task automatic write_px(input int ch, input int px, input logic [31:0] d);
      int waited = 0;
      ctrl_write      = 1'b1;
      ctrl_address    = {16'(ch), 16'(px)};
      ctrl_write_data = d;
      while (!ctrl_ready && waited < 8) begin
         @(negedge clock);
         waited++;
      end
      n_checks++;
      if (ctrl_ready !== 1'b1) begin
         $display("FAIL write_ready ch%0d px%0d: ready=%b, required 1", ch, px, ctrl_ready);
      end else begin
         n_pass++;
         model_write(ch, px, d);
         @(negedge clock);
      end
      ctrl_write = 1'b0;
   endtask

   task automatic read_check(input int ch, input int px, input string name);
      logic [31:0] exp;
      ctrl_address = {16'(ch), 16'(px)};
      @(negedge clock);
      exp = (ch < CH && px < PX) ? {8'h00, model[ch][px]} : 32'h0;
      n_checks++;
      if (ctrl_read_data !== exp)
         $display("FAIL %s: read ch%0d px%0d got %h want %h", name, ch, px, ctrl_read_data, exp);
      else
         n_pass++;
   endtask

   task automatic start_frame(input string name);
      int w = 0;
      ctrl_refresh = 1'b1;
      @(negedge clock);
      ctrl_refresh = 1'b0;
      while (busy !== 1'b1 && w < 10) begin
         @(negedge clock);
         w++;
      end
      n_checks++;
      if (busy !== 1'b1 || w != 0)
         $display("FAIL %s_start: busy=%b after %0d extra cycles, required 1 after 0", name, busy, w);
      else
         n_pass++;
   endtask

   // Walk one frame from its first busy cycle, comparing every drive bit with the timing model
   task automatic check_frame(input string name, input bit chained);
      logic [23:0] snap [CH];
      int   bad [CH];
      int   first_t [CH];
      logic first_got [CH];
      logic first_exp [CH];
      int   busy_bad = 0;
      int   p = 0, r = 0, k, ph, b;
      logic e;
      for (int c = 0; c < CH; c++) begin
         bad[c] = 0; first_t[c] = 0; first_got[c] = 1'b0; first_exp[c] = 1'b0; snap[c] = '0;
      end
      for (int t = 0; t < FRAME; t++) begin
         ctrl_write   = 1'b0;
         ctrl_refresh = 1'b0;
         if (t < PX * PXLEN) begin
            p = t / PXLEN;
            r = t % PXLEN;
            if (r == 0) for (int c = 0; c < CH; c++) snap[c] = model[c][p];
         end
         if (busy !== 1'b1) busy_bad++;
         for (int c = 0; c < CH; c++) begin
            e = 1'b0;
            if (t < PX * PXLEN && r >= 2) begin
               k  = (r - 2) / TBIT;
               ph = (r - 2) % TBIT;
               b  = BPP - 1 - k;
               e  = (ph < (snap[c][b] ? T1H : T0H));
            end
            if (neopixel_drive[c] !== e) begin
               if (bad[c] == 0) begin
                  first_t[c] = t; first_got[c] = neopixel_drive[c]; first_exp[c] = e;
               end
               bad[c]++;
            end
         end
         for (int i = 0; i < 3; i++) if (t == pl_t[i]) ctrl_refresh = 1'b1;
         for (int i = 0; i < 2; i++) begin
            if (t == wr_t[i]) begin
               ctrl_write      = 1'b1;
               ctrl_address    = {16'(wr_ch[i]), 16'(wr_px[i])};
               ctrl_write_data = wr_d[i];
               model_write(wr_ch[i], wr_px[i], wr_d[i]);
            end
         end
         @(negedge clock);
      end
      ctrl_write   = 1'b0;
      ctrl_refresh = 1'b0;
      for (int c = 0; c < CH; c++) begin
         n_checks++;
         if (bad[c] != 0)
            $display("FAIL %s_drive ch%0d: %0d wrong cycles, first t=%0d got %b want %b",
                     name, c, bad[c], first_t[c], first_got[c], first_exp[c]);
         else
            n_pass++;
      end
      n_checks++;
      if (busy_bad != 0)
         $display("FAIL %s_busy_frame: busy low on %0d of %0d frame cycles, required 0", name, busy_bad, FRAME);
      else
         n_pass++;
      n_checks++;
      if (busy !== chained)
         $display("FAIL %s_busy_end: busy=%b at cycle %0d, required %b", name, busy, FRAME, chained);
      else
         n_pass++;
   endtask

   task automatic fill_random();
      for (int c = 0; c < CH; c++)
         for (int p = 0; p < PX; p++)
            write_px(c, p, $urandom());
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (neopixel_drive !== '0) $display("FAIL reset_drive: got %b want 0", neopixel_drive); else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++;
      if (ctrl_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ctrl_ready); else n_pass++;
      n_checks++;
      if (ctrl_read_data !== 32'h0) $display("FAIL reset_rdata: got %h want 0", ctrl_read_data); else n_pass++;
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_first_pixel();
      for (int c = 0; c < CH; c++)
         for (int p = 0; p < PX; p++)
            write_px(c, p, (c == 0 && p == 0) ? 32'h0000_FF00 : 32'h0);
      clear_events();
      start_frame("first_pixel");
      check_frame("first_pixel", 1'b0);
      read_check(0, 0, "first_pixel_readback");
   endtask

   task automatic test_full_frame();
      fill_random();
      repeat (5) @(negedge clock);
      clear_events();
      start_frame("full_frame");
      check_frame("full_frame", 1'b0);
   endtask

   task automatic test_out_of_range();
      write_px(4, 0, $urandom());
      write_px(0, PX, $urandom());
      write_px(3, 1, $urandom());
      read_check(0, 0, "oor_ch0_px0");
      read_check(0, 1, "oor_ch0_px1");
      read_check(3, 1, "oor_ch3_px1");
      read_check(4, 0, "oor_read_ch4");
      read_check(0, PX, "oor_read_px");
      for (int i = 0; i < 3; i++)
         read_check($urandom_range(CH - 1), $urandom_range(PX - 1), "rand_read");
   endtask

   task automatic test_back_to_back();
      int idle_busy = 0;
      fill_random();
      clear_events();
      pl_t[0] = 100; pl_t[1] = 4000; pl_t[2] = FRAME - 5;
      wr_t[0] = 500; wr_ch[0] = 1; wr_px[0] = 1; wr_d[0] = $urandom();
      wr_t[1] = 600; wr_ch[1] = 2; wr_px[1] = 0; wr_d[1] = $urandom();
      start_frame("b2b");
      check_frame("b2b_first", 1'b1);
      clear_events();
      check_frame("b2b_second", 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (busy !== 1'b0) idle_busy++;
         @(negedge clock);
      end
      n_checks++;
      if (idle_busy != 0)
         $display("FAIL b2b_no_third: busy high on %0d idle cycles, required 0", idle_busy);
      else
         n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int t_rst;
      fill_random();
      write_px(0, 1, 32'h00FF_FFFF);
      clear_events();
      start_frame("mid_reset");
      t_rst = PXLEN + 2 + (BPP - 1 - 5) * TBIT + 10;
      repeat (t_rst) @(negedge clock);
      n_checks++;
      if (neopixel_drive[0] !== 1'b1)
         $display("FAIL mid_reset_pre: ch0 drive=%b, required 1", neopixel_drive[0]);
      else
         n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (neopixel_drive !== '0 || busy !== 1'b0)
         $display("FAIL mid_reset_async: drive=%b busy=%b, required 0 and 0", neopixel_drive, busy);
      else
         n_pass++;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++;
      if (ctrl_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL mid_reset_idle: ready=%b busy=%b, required 1 and 0", ctrl_ready, busy);
      else
         n_pass++;
      start_frame("after_reset");
      check_frame("after_reset", 1'b0);
   endtask

   initial begin
      reset_n         = 1'b0;
      ctrl_write      = 1'b0;
      ctrl_address    = '0;
      ctrl_write_data = '0;
      ctrl_refresh    = 1'b0;
      clear_events();
      @(negedge clock);
      test_reset();
      test_first_pixel();
      test_full_frame();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
